bp_update_ctrl: RTL and testbench
=================================

Name: bp_update_ctrl

Overview:
- In-order branch tracking queue that sequences training updates into the BRANCH_PRED table.
- Fetch allocates one entry per predicted branch (PC plus predicted direction). Execute resolves entries out of order by tag.
- Retires resolved entries from the head and drives the predictor's update port (vld/pc_past/taken) with at most one update per cycle.
- Detects mispredicts, squashes younger entries and reports a redirect.

Parameters:
- DEPTH, 8, number of in-flight branch entries (power of 2, >= 2)
- PC_W, 32, PC width
- TAG_W, 3, entry tag width, equals log2(DEPTH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_vld  in  1  fetch requests a new entry
- alloc_pc  in  PC_W  PC of the predicted branch
- alloc_pred  in  1  predicted direction (1 = taken)
- alloc_rdy  out  1  entry can be accepted this cycle
- alloc_tag  out  TAG_W  tag assigned to the entry when alloc_vld && alloc_rdy (current tail index)
- res_vld  in  1  execute resolves a branch
- res_tag  in  TAG_W  tag being resolved
- res_taken  in  1  actual direction
- upd_vld  out  1  predictor update strobe (to BRANCH_PRED vld)
- upd_pc  out  PC_W  update PC (to pc_past)
- upd_taken  out  1  update direction (to taken)
- mispredict  out  1  one-cycle pulse on mispredict
- redirect_pc  out  PC_W  PC of the mispredicted branch
- redirect_taken  out  1  correct direction of that branch
- count  out  TAG_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst low, asynchronous): head=0, tail=0, count=0, all entry valid/resolved bits cleared. upd_vld=0, upd_pc=0, upd_taken=0, mispredict=0, redirect_pc=0, redirect_taken=0. Reset mid-operation discards all entries; no update is issued for them.
- Entry fields: pc, pred, resolved, actual, valid.
- Live-entry test: a tag is live iff valid is set. Resolving a non-live or already-resolved tag is ignored (no mismatch, no squash).
- Mismatch: res_vld && live && !resolved && res_taken != pred[res_tag].
- alloc_rdy = (count != DEPTH) && !mismatch (combinational).
- Allocation: on an edge with alloc_vld && alloc_rdy, write the entry at tail, set valid=1, resolved=0, tail++ (wraps modulo DEPTH). alloc_vld with alloc_rdy=0 is dropped; fetch must hold it.
- Resolution: on an edge with res_vld on a live entry, set resolved=1 and actual=res_taken.
- Mismatch at edge N:
  - tail <= res_tag+1 mod DEPTH; entries strictly younger than res_tag get valid=0.
  - count <= ((res_tag - head) mod DEPTH) + 1, adjusted by a same-edge retire.
  - mispredict=1, redirect_pc=pc[res_tag], redirect_taken=res_taken during cycle N+1 only.
- Retire: on an edge where count != 0 and head entry is valid && resolved:
  - upd_vld<=1, upd_pc<=pc[head], upd_taken<=actual[head], head++, valid[head]<=0.
  - Otherwise upd_vld<=0; upd_pc/upd_taken hold their last value.
  - Exactly one retire per cycle, strictly in allocation order.
- Latency:
  - res at edge N -> head retire at edge N+1 -> upd_vld high during cycle N+2.
  - A resolved non-head entry waits until all older entries retire.
- Simultaneous alloc and retire: both take effect, count unchanged.
- Simultaneous alloc and mismatch: alloc is blocked by alloc_rdy=0.
- Simultaneous retire and mismatch on the same tag (head): the mismatch squashes younger entries; the head retires on a later edge as normal.
- Full (count=DEPTH): alloc_rdy=0; retire frees one slot on the next cycle.
- Empty: no upd_vld.
- Wrap: head and tail wrap modulo DEPTH; full vs. empty is distinguished by count.

Test Plan:
- Reset with rst low mid-run (3 live entries) -> count=0, alloc_tag=0, upd_vld=0, mispredict=0 immediately.
- Fill 8 entries PC 0x100..0x107, pred=1 -> tags 0..7, alloc_rdy=0 at count=8. Resolve tag 0 taken -> upd_vld pulse 2 cycles later with upd_pc=0x100, upd_taken=1; alloc_rdy=1 next cycle.
- Out-of-order resolve: allocate 0x200,0x204,0x208 (tags 0,1,2), resolve 2, then 1, then 0, all correct -> updates issued in order 0x200,0x204,0x208 on consecutive cycles, mispredict never asserted.
- Mispredict squash: allocate 4 entries pred=1, resolve tag 1 with res_taken=0 -> mispredict=1 for one cycle, redirect_pc=PC of tag 1, redirect_taken=0, count=2. Later resolve of tag 3 ignored. Next alloc_tag=2.
- Alloc during mismatch cycle -> alloc_rdy=0, entry not written, count unchanged by alloc.
- Wrap-around: run 20 allocate/resolve pairs with 0xffff always taken -> upd_pc=0xffff 20 times, head/tail wrap past 7, count returns to 0.

Source files
------------

// File: rtl/bp_update_ctrl.sv
// In-order branch tracking queue: fetch allocates, execute resolves out of order,
// resolved entries retire from the head as branch-predictor training updates.
module bp_update_ctrl #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_vld,
    input  logic [PC_W-1:0]  alloc_pc,
    input  logic             alloc_pred,
    output logic             alloc_rdy,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_vld,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    output logic             upd_vld,
    output logic [PC_W-1:0]  upd_pc,
    output logic             upd_taken,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             redirect_taken,
    output logic [TAG_W:0]   count
);

    localparam int CW = TAG_W + 1;

    logic [PC_W-1:0]  pc_q [DEPTH];
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] resolved_q;
    logic [DEPTH-1:0] actual_q;
    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CW-1:0]    count_q;

    logic             res_live;
    logic             res_accept;
    logic             mismatch;
    logic             do_alloc;
    logic             retire;
    logic [TAG_W-1:0] res_dist;

    // Age of slot idx relative to the head; larger means younger.
    function automatic logic [TAG_W-1:0] age_of(input int idx, input logic [TAG_W-1:0] hd);
        logic [TAG_W-1:0] t;
        t = TAG_W'(idx);
        return t - hd;
    endfunction

    assign res_live   = valid_q[res_tag];
    assign res_accept = res_vld && res_live && !resolved_q[res_tag];
    assign mismatch   = res_accept && (res_taken != pred_q[res_tag]);
    assign alloc_rdy  = (count_q != CW'(DEPTH)) && !mismatch;
    assign alloc_tag  = tail;
    assign do_alloc   = alloc_vld && alloc_rdy;
    assign retire     = (count_q != '0) && valid_q[head] && resolved_q[head];
    assign res_dist   = res_tag - head;
    assign count      = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
            end
            pred_q         <= '0;
            resolved_q     <= '0;
            actual_q       <= '0;
            valid_q        <= '0;
            head           <= '0;
            tail           <= '0;
            count_q        <= '0;
            upd_vld        <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            redirect_taken <= 1'b0;
        end else begin
            if (res_accept) begin
                resolved_q[res_tag] <= 1'b1;
                actual_q[res_tag]   <= res_taken;
            end

            // A mismatch never coincides with an allocation (alloc_rdy is low).
            if (mismatch) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (age_of(i, head) > res_dist) begin
                        valid_q[i]    <= 1'b0;
                        resolved_q[i] <= 1'b0;
                    end
                end
                tail    <= res_tag + 1'b1;
                count_q <= CW'(res_dist) + CW'(1) - CW'(retire);
            end else begin
                if (do_alloc) begin
                    pc_q[tail]       <= alloc_pc;
                    pred_q[tail]     <= alloc_pred;
                    resolved_q[tail] <= 1'b0;
                    actual_q[tail]   <= 1'b0;
                    valid_q[tail]    <= 1'b1;
                    tail             <= tail + 1'b1;
                end
                count_q <= count_q + CW'(do_alloc) - CW'(retire);
            end

            if (retire) begin
                upd_vld          <= 1'b1;
                upd_pc           <= pc_q[head];
                upd_taken        <= actual_q[head];
                valid_q[head]    <= 1'b0;
                resolved_q[head] <= 1'b0;
                head             <= head + 1'b1;
            end else begin
                upd_vld <= 1'b0;
            end

            mispredict <= mismatch;
            if (mismatch) begin
                redirect_pc    <= pc_q[res_tag];
                redirect_taken <= res_taken;
            end
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scenario bench for bp_update_ctrl: expected updates and redirects are queued
// as stimulus is driven and popped by a monitor as the DUT emits them.
module tb_bp_update_ctrl;

    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int TAG_W = 3;

    logic             clk;
    logic             rst;
    logic             alloc_vld;
    logic [PC_W-1:0]  alloc_pc;
    logic             alloc_pred;
    logic             alloc_rdy;
    logic [TAG_W-1:0] alloc_tag;
    logic             res_vld;
    logic [TAG_W-1:0] res_tag;
    logic             res_taken;
    logic             upd_vld;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic             redirect_taken;
    logic [TAG_W:0]   count;

    bp_update_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_rdy(alloc_rdy), .alloc_tag(alloc_tag),
        .res_vld(res_vld), .res_tag(res_tag), .res_taken(res_taken),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .redirect_taken(redirect_taken), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } ev_t;

    ev_t upd_q[$];
    ev_t redir_q[$];
    ev_t mon_e;
    int  total = 0;
    int  bad = 0;
    int  upd_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (upd_vld) begin
                upd_seen++;
                total++;
                if (upd_q.size() == 0) begin
                    bad++;
                    $display("FAIL upd_unexpected: got pc=%h taken=%b, required no update", upd_pc, upd_taken);
                end else begin
                    mon_e = upd_q.pop_front();
                    if (upd_pc !== mon_e.pc || upd_taken !== mon_e.taken) begin
                        bad++;
                        $display("FAIL upd_value: got pc=%h taken=%b, required pc=%h taken=%b",
                                 upd_pc, upd_taken, mon_e.pc, mon_e.taken);
                    end
                end
            end
            if (mispredict) begin
                total++;
                if (redir_q.size() == 0) begin
                    bad++;
                    $display("FAIL mispredict_unexpected: got pc=%h taken=%b, required none", redirect_pc, redirect_taken);
                end else begin
                    mon_e = redir_q.pop_front();
                    if (redirect_pc !== mon_e.pc || redirect_taken !== mon_e.taken) begin
                        bad++;
                        $display("FAIL redirect_value: got pc=%h taken=%b, required pc=%h taken=%b",
                                 redirect_pc, redirect_taken, mon_e.pc, mon_e.taken);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    // Stimulus helpers: all start and end at posedge+1.
    task automatic do_alloc(input logic [PC_W-1:0] pc, input logic pred, output logic [TAG_W-1:0] tag);
        int n = 0;
        alloc_vld = 1'b1; alloc_pc = pc; alloc_pred = pred;
        #1;
        while (!alloc_rdy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) begin
            total++; bad++;
            $display("FAIL alloc_timeout: got alloc_rdy=0, required 1");
        end
        tag = alloc_tag;
        @(posedge clk); #1;
        alloc_vld = 1'b0;
    endtask

    task automatic do_resolve(input logic [TAG_W-1:0] tag, input logic taken);
        res_vld = 1'b1; res_tag = tag; res_taken = taken;
        @(posedge clk); #1;
        res_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (upd_q.size() != 0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; alloc_vld = 1'b0; alloc_pc = '0; alloc_pred = 1'b0;
        res_vld = 1'b0; res_tag = '0; res_taken = 1'b0;
        #2;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d required 0", count); end
        total++; if (alloc_tag !== 3'd0) begin bad++; $display("FAIL rst_tag: got %0d required 0", alloc_tag); end
        total++; if (upd_vld !== 1'b0) begin bad++; $display("FAIL rst_upd_vld: got %b required 0", upd_vld); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_mispredict: got %b required 0", mispredict); end
        total++; if (alloc_rdy !== 1'b1) begin bad++; $display("FAIL rst_alloc_rdy: got %b required 1", alloc_rdy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        logic [TAG_W-1:0] t;
        for (int i = 0; i < 3; i++) do_alloc(32'h50 + i, 1'b1, t);
        do_resolve(3'd1, 1'b1);
        total++; if (count !== 4'd3) begin bad++; $display("FAIL mid_count_pre: got %0d required 3", count); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_count: got %0d required 0", count); end
        total++; if (alloc_tag !== 3'd0) begin bad++; $display("FAIL mid_tag: got %0d required 0", alloc_tag); end
        total++; if (upd_vld !== 1'b0) begin bad++; $display("FAIL mid_upd_vld: got %b required 0", upd_vld); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL mid_mispredict: got %b required 0", mispredict); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_fill();
        logic [TAG_W-1:0] t;
        for (int i = 0; i < DEPTH; i++) begin
            do_alloc(32'h100 + i, 1'b1, t);
            total++;
            if (t !== TAG_W'(i)) begin bad++; $display("FAIL fill_tag: got %0d required %0d", t, i); end
        end
        total++; if (alloc_rdy !== 1'b0) begin bad++; $display("FAIL full_rdy: got %b required 0", alloc_rdy); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count: got %0d required 8", count); end
        upd_q.push_back('{pc: 32'h100, taken: 1'b1});
        do_resolve(3'd0, 1'b1);
        total++; if (upd_vld !== 1'b0) begin bad++; $display("FAIL fill_early_upd: got %b required 0", upd_vld); end
        @(posedge clk); #1;
        total++;
        if (upd_vld !== 1'b1 || upd_pc !== 32'h100 || upd_taken !== 1'b1) begin
            bad++; $display("FAIL fill_upd: got vld=%b pc=%h taken=%b required 1 100 1", upd_vld, upd_pc, upd_taken);
        end
        total++; if (alloc_rdy !== 1'b1) begin bad++; $display("FAIL fill_rdy_after: got %b required 1", alloc_rdy); end
        total++; if (count !== 4'd7) begin bad++; $display("FAIL fill_count_after: got %0d required 7", count); end
        for (int i = 1; i < DEPTH; i++) begin
            upd_q.push_back('{pc: 32'h100 + i, taken: 1'b1});
            do_resolve(TAG_W'(i), 1'b1);
        end
        wait_drain();
        total++; if (upd_q.size() != 0) begin bad++; $display("FAIL fill_drain: got %0d pending required 0", upd_q.size()); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL fill_count_end: got %0d required 0", count); end
    endtask

    task automatic test_out_of_order();
        logic [TAG_W-1:0] t [3];
        for (int i = 0; i < 3; i++) begin
            upd_q.push_back('{pc: 32'h200 + 4 * i, taken: 1'b1});
            do_alloc(32'h200 + 4 * i, 1'b1, t[i]);
            total++;
            if (t[i] !== TAG_W'(i)) begin bad++; $display("FAIL ooo_tag: got %0d required %0d", t[i], i); end
        end
        do_resolve(t[2], 1'b1);
        do_resolve(t[1], 1'b1);
        do_resolve(t[0], 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (upd_vld !== 1'b1 || upd_pc !== 32'h200 + 4 * k) begin
                bad++; $display("FAIL ooo_order: got vld=%b pc=%h required 1 %h", upd_vld, upd_pc, 32'h200 + 4 * k);
            end
        end
        wait_drain();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL ooo_count: got %0d required 0", count); end
    endtask

    task automatic test_mispredict();
        logic [TAG_W-1:0] t [4];
        for (int i = 0; i < 4; i++) do_alloc(32'h300 + 4 * i, 1'b1, t[i]);
        total++; if (t[0] !== 3'd3) begin bad++; $display("FAIL mp_base_tag: got %0d required 3", t[0]); end
        redir_q.push_back('{pc: 32'h304, taken: 1'b0});
        do_resolve(t[1], 1'b0);
        total++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h304 || redirect_taken !== 1'b0) begin
            bad++; $display("FAIL mp_pulse: got mp=%b pc=%h taken=%b required 1 304 0", mispredict, redirect_pc, redirect_taken);
        end
        total++; if (count !== 4'd2) begin bad++; $display("FAIL mp_count: got %0d required 2", count); end
        do_resolve(t[3], 1'b1);
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL mp_one_cycle: got %b required 0", mispredict); end
        total++; if (count !== 4'd2) begin bad++; $display("FAIL mp_squashed_ignored: got %0d required 2", count); end
        total++; if (alloc_tag !== t[2]) begin bad++; $display("FAIL mp_next_tag: got %0d required %0d", alloc_tag, t[2]); end
        upd_q.push_back('{pc: 32'h300, taken: 1'b1});
        upd_q.push_back('{pc: 32'h304, taken: 1'b0});
        do_resolve(t[0], 1'b1);
        wait_drain();
        total++; if (upd_q.size() != 0 || count !== 4'd0) begin
            bad++; $display("FAIL mp_drain: got pending=%0d count=%0d required 0 0", upd_q.size(), count);
        end
    endtask

    task automatic test_alloc_during_mismatch();
        logic [TAG_W-1:0] t0, t1;
        do_alloc(32'h400, 1'b0, t0);
        do_alloc(32'h404, 1'b0, t1);
        res_vld = 1'b1; res_tag = t0; res_taken = 1'b1;
        alloc_vld = 1'b1; alloc_pc = 32'h4ff; alloc_pred = 1'b1;
        #1;
        total++; if (alloc_rdy !== 1'b0) begin bad++; $display("FAIL amm_rdy: got %b required 0", alloc_rdy); end
        redir_q.push_back('{pc: 32'h400, taken: 1'b1});
        upd_q.push_back('{pc: 32'h400, taken: 1'b1});
        @(posedge clk); #1;
        res_vld = 1'b0; alloc_vld = 1'b0;
        total++; if (count !== 4'd1) begin bad++; $display("FAIL amm_count: got %0d required 1", count); end
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL amm_mp: got %b required 1", mispredict); end
        total++; if (alloc_tag !== t1) begin bad++; $display("FAIL amm_tag: got %0d required %0d", alloc_tag, t1); end
        @(posedge clk); #1;
        total++;
        if (upd_vld !== 1'b1 || upd_pc !== 32'h400 || count !== 4'd0) begin
            bad++; $display("FAIL amm_retire: got vld=%b pc=%h count=%0d required 1 400 0", upd_vld, upd_pc, count);
        end
        wait_drain();
    endtask

    task automatic test_wrap();
        logic [TAG_W-1:0] t;
        int seen0;
        seen0 = upd_seen;
        for (int i = 0; i < 20; i++) begin
            upd_q.push_back('{pc: 32'hffff, taken: 1'b1});
            do_alloc(32'hffff, 1'b1, t);
            do_resolve(t, 1'b1);
        end
        wait_drain();
        total++; if (upd_seen - seen0 != 20) begin bad++; $display("FAIL wrap_updates: got %0d required 20", upd_seen - seen0); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_count: got %0d required 0", count); end
        total++; if (upd_q.size() != 0) begin bad++; $display("FAIL wrap_pending: got %0d required 0", upd_q.size()); end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_fill();
        test_out_of_order();
        test_mispredict();
        test_alloc_during_mismatch();
        test_wrap();
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (redir_q.size() != 0) begin bad++; $display("FAIL redirect_pending: got %0d required 0", redir_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
